// File: rtl/mochila_ext_slave_bridge.sv
// Buffered OBI bridge downstream of mochila_top's external slave port: request FIFO,
// outstanding-transaction limit, registered in-order responses and a sticky protocol error.
package mochila_ext_slave_bridge_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module mochila_ext_slave_bridge
    import mochila_ext_slave_bridge_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  obi_req_t                               slv_req_i,
    output obi_resp_t                              slv_resp_o,
    output obi_req_t                               mst_req_o,
    input  obi_resp_t                              mst_resp_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_full, fifo_empty;
    logic          gnt, accept, pop, solicited;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic [CW-1:0] count_q, pending_q;
    logic          err_q;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Grant uses pre-pop occupancy, so a full FIFO never grants even while it drains.
    assign gnt       = slv_req_i.req && !fifo_full && (count_q < MAX_CNT);
    assign accept    = gnt;
    assign pop       = !fifo_empty && mst_resp_i.gnt;
    assign solicited = mst_resp_i.rvalid && (pending_q != '0);

    always_comb begin
        slv_resp_o        = '0;
        slv_resp_o.gnt    = gnt;
        slv_resp_o.rvalid = rvalid_q;
        slv_resp_o.rdata  = rdata_q;
    end

    always_comb begin
        mst_req_o = '0;
        if (!fifo_empty) begin
            mst_req_o.req   = 1'b1;
            mst_req_o.we    = mem[rd_ptr[AW-1:0]].we;
            mst_req_o.be    = mem[rd_ptr[AW-1:0]].be;
            mst_req_o.addr  = mem[rd_ptr[AW-1:0]].addr;
            mst_req_o.wdata = mem[rd_ptr[AW-1:0]].wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= '{we: slv_req_i.we, be: slv_req_i.be,
                                     addr: slv_req_i.addr, wdata: slv_req_i.wdata};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= solicited;
            if (solicited) rdata_q <= mst_resp_i.rdata;
        end
    end

    // Upstream count closes on the forwarded rvalid; downstream count closes on the raw rvalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case ({accept, rvalid_q})
                2'b10:   if (count_q != MAX_CNT) count_q <= count_q + 1'b1;
                2'b01:   if (count_q != '0)      count_q <= count_q - 1'b1;
                default: ;
            endcase
            case ({pop, solicited})
                2'b10:   if (pending_q != MAX_CNT) pending_q <= pending_q + 1'b1;
                2'b01:   pending_q <= pending_q - 1'b1;
                default: ;
            endcase
            if (mst_resp_i.rvalid && (pending_q == '0)) err_q <= 1'b1;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_mochila_ext_slave_bridge.sv
// Self-checking bench for mochila_ext_slave_bridge: table-driven single transactions,
// hand-written corner sequences, and a negedge scoreboard/reference model.
module tb_mochila_ext_slave_bridge;
    import mochila_ext_slave_bridge_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXO  = 4;
    localparam int CW    = $clog2(MAXO + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    obi_req_t      slv_req_i, mst_req_o;
    obi_resp_t     slv_resp_o, mst_resp_i;
    logic [CW-1:0] outstanding_o;
    logic          err_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs [4];

    obi_req_t    req_q [$];
    logic [31:0] rsp_q [$];
    obi_req_t    exp_req;
    int          m_fifo = 0, m_out = 0, m_pend = 0;
    logic        m_err = 1'b0;

    mochila_ext_slave_bridge #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .slv_req_i(slv_req_i), .slv_resp_o(slv_resp_o),
        .mst_req_o(mst_req_o), .mst_resp_i(mst_resp_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                 input logic [31:0] wdata, input int budget, output bit accepted);
        slv_req_i = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
        accepted  = 1'b0;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk_i);
            accepted = slv_resp_o.gnt;
            step();
        end
        slv_req_i.req = 1'b0;
    endtask

    task automatic respondAll();
        for (int i = 0; i < 16 && m_pend > 0; i++) begin
            mst_resp_i.rvalid = 1'b1;
            mst_resp_i.rdata  = $urandom;
            step();
        end
        mst_resp_i.rvalid = 1'b0;
        repeat (2) step();
    endtask

    // Reference model: compare registered state first, then fold in this cycle's events.
    always @(negedge clk_i) begin
        checkOutput("outstanding", 32'(outstanding_o), 32'(m_out));
        checkOutput("err", 32'(err_o), 32'(m_err));
        checkOutput("mst_req", 32'(mst_req_o.req), 32'(m_fifo != 0));
        checkOutput("slv_gnt", 32'(slv_resp_o.gnt),
                    32'(slv_req_i.req && m_fifo < DEPTH && m_out < MAXO));
        if (rst_i) begin
            req_q.delete();
            rsp_q.delete();
            m_fifo = 0; m_out = 0; m_pend = 0; m_err = 1'b0;
        end else begin
            if (slv_resp_o.rvalid) begin
                if (rsp_q.size() == 0) checkOutput("rsp_unexpected", 32'(1), 32'(0));
                else checkOutput("sb_rdata", slv_resp_o.rdata, rsp_q.pop_front());
                if (m_out > 0) m_out--;
            end
            if (mst_resp_i.rvalid) begin
                if (m_pend > 0) begin
                    rsp_q.push_back(mst_resp_i.rdata);
                    m_pend--;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (mst_req_o.req && mst_resp_i.gnt) begin
                if (req_q.size() == 0) begin
                    checkOutput("req_unexpected", 32'(1), 32'(0));
                end else begin
                    exp_req = req_q.pop_front();
                    checkOutput("sb_addr", mst_req_o.addr, exp_req.addr);
                    checkOutput("sb_we", 32'(mst_req_o.we), 32'(exp_req.we));
                    checkOutput("sb_be", 32'(mst_req_o.be), 32'(exp_req.be));
                    checkOutput("sb_wdata", mst_req_o.wdata, exp_req.wdata);
                    m_fifo--;
                    m_pend++;
                end
            end
            if (slv_req_i.req && slv_resp_o.gnt) begin
                req_q.push_back(slv_req_i);
                m_fifo++;
                m_out++;
            end
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog expired actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit acc;
        int nacc;

        vecs[0] = '{addr: 32'h2000_0010, we: 1'b1, be: 4'hF, wdata: 32'hDEAD_BEEF, rdata: 32'h0000_0000};
        vecs[1] = '{addr: 32'h2000_0100, we: 1'b0, be: 4'hF, wdata: 32'h0,         rdata: 32'hCAFE_F00D};
        vecs[2] = '{addr: 32'h2000_0204, we: 1'b1, be: 4'h3, wdata: 32'h0000_A5A5, rdata: 32'h0BAD_0001};
        vecs[3] = '{addr: 32'h2FFF_FFFC, we: 1'b0, be: 4'hC, wdata: 32'h0,         rdata: 32'hFFFF_FFFF};

        slv_req_i  = '0;
        mst_resp_i = '0;
        rst_i      = 1'b1;
        repeat (2) step();
        rst_i = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_slv_rvalid", 32'(slv_resp_o.rvalid), 32'(0));
        checkOutput("rst_slv_rdata", slv_resp_o.rdata, 32'h0);
        checkOutput("rst_mst_req", 32'(mst_req_o.req), 32'(0));
        checkOutput("rst_mst_addr", mst_req_o.addr, 32'h0);
        checkOutput("rst_outstanding", 32'(outstanding_o), 32'(0));
        checkOutput("rst_err", 32'(err_o), 32'(0));

        $display("[TB] test 1: single transactions");
        mst_resp_i.gnt = 1'b1;
        for (int v = 0; v < 4; v++) begin
            checkOutput("t1_out_before", 32'(outstanding_o), 32'(0));
            applyStimulus(vecs[v].addr, vecs[v].we, vecs[v].be, vecs[v].wdata, 4, acc);
            checkOutput("t1_accepted", 32'(acc), 32'(1));
            checkOutput("t1_mst_req", 32'(mst_req_o.req), 32'(1));
            checkOutput("t1_mst_addr", mst_req_o.addr, vecs[v].addr);
            checkOutput("t1_out_one", 32'(outstanding_o), 32'(1));
            step();
            step();
            mst_resp_i.rvalid = 1'b1;
            mst_resp_i.rdata  = vecs[v].rdata;
            step();
            mst_resp_i.rvalid = 1'b0;
            mst_resp_i.rdata  = 32'h5555_5555;
            checkOutput("t1_slv_rvalid", 32'(slv_resp_o.rvalid), 32'(1));
            checkOutput("t1_slv_rdata", slv_resp_o.rdata, vecs[v].rdata);
            step();
            checkOutput("t1_out_after", 32'(outstanding_o), 32'(0));
            checkOutput("t1_rvalid_low", 32'(slv_resp_o.rvalid), 32'(0));
            checkOutput("t1_rdata_hold", slv_resp_o.rdata, vecs[v].rdata);
        end

        $display("[TB] test 2: back-pressure");
        mst_resp_i.gnt = 1'b0;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h3000_0000 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 3, acc);
            nacc += int'(acc);
            checkOutput("t2_head_stable", mst_req_o.addr, 32'h3000_0000);
        end
        checkOutput("t2_accept_count", 32'(nacc), 32'(DEPTH));
        slv_req_i.req = 1'b1;
        #1;
        checkOutput("t2_gnt_full", 32'(slv_resp_o.gnt), 32'(0));
        slv_req_i.req = 1'b0;
        mst_resp_i.gnt = 1'b1;
        repeat (3) step();
        checkOutput("t2_drained", 32'(mst_req_o.req), 32'(0));
        respondAll();
        for (int i = 2; i < 5; i++) begin
            applyStimulus(32'h3000_0000 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 5, acc);
            checkOutput("t2_late_accept", 32'(acc), 32'(1));
        end
        step();
        respondAll();

        $display("[TB] test 3: outstanding limit");
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'h4000_0000 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 3, acc);
            nacc += int'(acc);
        end
        checkOutput("t3_accept_count", 32'(nacc), 32'(MAXO));
        checkOutput("t3_outstanding", 32'(outstanding_o), 32'(MAXO));
        mst_resp_i.rvalid = 1'b1;
        mst_resp_i.rdata  = 32'h0000_3333;
        step();
        mst_resp_i.rvalid = 1'b0;
        step();
        applyStimulus(32'h4000_0100, 1'b0, 4'hF, 32'h0, 1, acc);
        checkOutput("t3_regrant", 32'(acc), 32'(1));
        checkOutput("t3_out_full_again", 32'(outstanding_o), 32'(MAXO));
        step();
        respondAll();

        $display("[TB] test 4: simultaneous push/pop and accept/response");
        applyStimulus(32'h5000_0000, 1'b0, 4'hF, 32'h0, 3, acc);
        step();
        mst_resp_i.gnt = 1'b0;
        applyStimulus(32'h5000_0004, 1'b0, 4'hF, 32'h0, 3, acc);
        checkOutput("t4_out_two", 32'(outstanding_o), 32'(2));
        mst_resp_i.rvalid = 1'b1;
        mst_resp_i.rdata  = 32'h1234_5678;
        step();
        mst_resp_i.rvalid = 1'b0;
        mst_resp_i.gnt    = 1'b1;
        slv_req_i = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h5000_0008, wdata: 32'h7777_0000};
        checkOutput("t4_slv_rvalid", 32'(slv_resp_o.rvalid), 32'(1));
        checkOutput("t4_slv_rdata", slv_resp_o.rdata, 32'h1234_5678);
        checkOutput("t4_head_b", mst_req_o.addr, 32'h5000_0004);
        #1;
        checkOutput("t4_gnt", 32'(slv_resp_o.gnt), 32'(1));
        step();
        slv_req_i.req  = 1'b0;
        mst_resp_i.gnt = 1'b0;
        checkOutput("t4_out_still_two", 32'(outstanding_o), 32'(2));
        checkOutput("t4_occupancy", 32'(mst_req_o.req), 32'(1));
        checkOutput("t4_head_c", mst_req_o.addr, 32'h5000_0008);
        mst_resp_i.gnt = 1'b1;
        step();
        respondAll();

        $display("[TB] test 5: unsolicited rvalid");
        mst_resp_i.rvalid = 1'b1;
        mst_resp_i.rdata  = 32'h0000_0BAD;
        step();
        mst_resp_i.rvalid = 1'b0;
        checkOutput("t5_err_set", 32'(err_o), 32'(1));
        checkOutput("t5_no_fwd", 32'(slv_resp_o.rvalid), 32'(0));
        step();
        step();
        checkOutput("t5_err_sticky", 32'(err_o), 32'(1));
        checkOutput("t5_out_zero", 32'(outstanding_o), 32'(0));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checkOutput("t5_err_cleared", 32'(err_o), 32'(0));

        $display("[TB] test 6: reset mid-operation");
        applyStimulus(32'h6000_0000, 1'b0, 4'hF, 32'h0, 3, acc);
        step();
        mst_resp_i.gnt = 1'b0;
        applyStimulus(32'h6000_0004, 1'b0, 4'hF, 32'h0, 3, acc);
        applyStimulus(32'h6000_0008, 1'b0, 4'hF, 32'h0, 3, acc);
        checkOutput("t6_out_pre", 32'(outstanding_o), 32'(3));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checkOutput("t6_mst_req", 32'(mst_req_o.req), 32'(0));
        checkOutput("t6_out_zero", 32'(outstanding_o), 32'(0));
        mst_resp_i.rvalid = 1'b1;
        mst_resp_i.rdata  = 32'h0000_0666;
        step();
        mst_resp_i.rvalid = 1'b0;
        checkOutput("t6_stale_err", 32'(err_o), 32'(1));
        checkOutput("t6_no_fwd", 32'(slv_resp_o.rvalid), 32'(0));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
